// File: rtl/line_buffer_ctrl.sv
// Line-RAM bank sequencer for the vertical-window path: rotates raster writes across LINES banks
// and emits a column-window strobe aligned to the 1-cycle RAM read. Option: LINE_BUFFER_CTRL_EARLY_OUT_EN.
module line_buffer_ctrl #(
    parameter  int WIDTH_MAX  = 2048,
    parameter  int LINES      = 3,
    parameter  int PIXEL_BITW = 8,
    localparam int ADDR_BITW  = $clog2(WIDTH_MAX),
    localparam int BANK_BITW  = $clog2(LINES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_frame_start,
    input  logic [ADDR_BITW:0]    in_width,
    input  logic                  in_valid,
    input  logic [PIXEL_BITW-1:0] in_pixel,
    output logic [LINES-1:0]      ram_wr_en,
    output logic [ADDR_BITW-1:0]  ram_wr_addr,
    output logic [PIXEL_BITW-1:0] ram_wr_data,
    output logic [ADDR_BITW-1:0]  ram_rd_addr,
    output logic                  out_valid,
    output logic [PIXEL_BITW-1:0] out_pixel,
    output logic [ADDR_BITW-1:0]  out_col,
    output logic                  out_last_col,
    output logic [BANK_BITW-1:0]  out_oldest_bank,
    output logic [BANK_BITW:0]    out_fill
);

    localparam logic [ADDR_BITW:0]   WIDTH_ALL = (ADDR_BITW+1)'(WIDTH_MAX);
    localparam logic [ADDR_BITW:0]   WIDTH_ONE = (ADDR_BITW+1)'(1);
    localparam logic [ADDR_BITW-1:0] COL_ONE   = ADDR_BITW'(1);
    localparam logic [BANK_BITW-1:0] BANK_LAST = BANK_BITW'(LINES-1);
    localparam logic [BANK_BITW-1:0] BANK_ONE  = BANK_BITW'(1);
    localparam logic [BANK_BITW:0]   FILL_FULL = (BANK_BITW+1)'(LINES-1);
    localparam logic [BANK_BITW:0]   FILL_ONE  = (BANK_BITW+1)'(1);
    localparam logic [LINES-1:0]     EN_ONE    = LINES'(1);

    // Line position state
    logic [ADDR_BITW-1:0]  col;
    logic [BANK_BITW-1:0]  wr_bank;
    logic [BANK_BITW:0]    fill;
    logic [ADDR_BITW:0]    width_r;

    // Counter view for this cycle: a frame start clears them before the pixel is applied
    logic [ADDR_BITW:0]    width_sel;
    logic [ADDR_BITW-1:0]  cur_col;
    logic [BANK_BITW-1:0]  cur_bank;
    logic [BANK_BITW:0]    cur_fill;
    logic [ADDR_BITW:0]    cur_width;
    logic                  line_end;
    logic                  qualify;
    logic [BANK_BITW-1:0]  oldest;
    logic [ADDR_BITW-1:0]  col_nx;
    logic [BANK_BITW-1:0]  bank_nx;
    logic [BANK_BITW:0]    fill_nx;

    // Stage 1 side-band travelling alongside the RAM read
    logic                  s1_valid;
    logic [PIXEL_BITW-1:0] s1_pixel;
    logic [ADDR_BITW-1:0]  s1_col;
    logic                  s1_last;
    logic [BANK_BITW-1:0]  s1_oldest;
    logic [BANK_BITW:0]    s1_fill;

    always_comb begin
        width_sel = in_width;
        // Zero means a full-width line; oversize widths are clamped so col can always wrap
        if (in_width == '0 || in_width > WIDTH_ALL) begin
            width_sel = WIDTH_ALL;
        end

        cur_col   = in_frame_start ? '0 : col;
        cur_bank  = in_frame_start ? '0 : wr_bank;
        cur_fill  = in_frame_start ? '0 : fill;
        cur_width = in_frame_start ? width_sel : width_r;

        line_end = ({1'b0, cur_col} == (cur_width - WIDTH_ONE));
        oldest   = (cur_bank == BANK_LAST) ? '0 : cur_bank + BANK_ONE;

`ifdef LINE_BUFFER_CTRL_EARLY_OUT_EN
        qualify = 1'b1;
`else
        qualify = (cur_fill == FILL_FULL);
`endif

        col_nx  = cur_col;
        bank_nx = cur_bank;
        fill_nx = cur_fill;
        if (in_valid) begin
            if (line_end) begin
                col_nx  = '0;
                bank_nx = (cur_bank == BANK_LAST) ? '0 : cur_bank + BANK_ONE;
                fill_nx = (cur_fill == FILL_FULL) ? FILL_FULL : cur_fill + FILL_ONE;
            end else begin
                col_nx = cur_col + COL_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col     <= '0;
            wr_bank <= '0;
            fill    <= '0;
            width_r <= WIDTH_ALL;
        end else begin
            col     <= col_nx;
            wr_bank <= bank_nx;
            fill    <= fill_nx;
            width_r <= cur_width;
        end
    end

    // Stage 1: RAM write/read port registers; addresses hold between accepts
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_wr_en   <= '0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_addr <= '0;
            s1_valid    <= 1'b0;
            s1_pixel    <= '0;
            s1_col      <= '0;
            s1_last     <= 1'b0;
            s1_oldest   <= '0;
            s1_fill     <= '0;
        end else if (in_valid) begin
            ram_wr_en   <= EN_ONE << cur_bank;
            ram_wr_addr <= cur_col;
            ram_wr_data <= in_pixel;
            ram_rd_addr <= cur_col;
            s1_valid    <= qualify;
            s1_pixel    <= in_pixel;
            s1_col      <= cur_col;
            s1_last     <= line_end;
            s1_oldest   <= oldest;
            s1_fill     <= cur_fill;
        end else begin
            ram_wr_en <= '0;
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: lines up with bank rd_data
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_pixel       <= '0;
            out_col         <= '0;
            out_last_col    <= 1'b0;
            out_oldest_bank <= '0;
            out_fill        <= '0;
        end else begin
            out_valid       <= s1_valid;
            out_pixel       <= s1_pixel;
            out_col         <= s1_col;
            out_last_col    <= s1_last;
            out_oldest_bank <= s1_oldest;
            out_fill        <= s1_fill;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed + random bench for line_buffer_ctrl; expectations derive bank/column/fill from
// the pixel index within the frame.
module tb_line_buffer_ctrl;

    localparam int WIDTH_MAX  = 16;
    localparam int LINES      = 3;
    localparam int PIXEL_BITW = 8;
    localparam int ADDR_BITW  = 4;
    localparam int BANK_BITW  = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_frame_start;
    logic [ADDR_BITW:0]    in_width;
    logic                  in_valid;
    logic [PIXEL_BITW-1:0] in_pixel;
    logic [LINES-1:0]      ram_wr_en;
    logic [ADDR_BITW-1:0]  ram_wr_addr;
    logic [PIXEL_BITW-1:0] ram_wr_data;
    logic [ADDR_BITW-1:0]  ram_rd_addr;
    logic                  out_valid;
    logic [PIXEL_BITW-1:0] out_pixel;
    logic [ADDR_BITW-1:0]  out_col;
    logic                  out_last_col;
    logic [BANK_BITW-1:0]  out_oldest_bank;
    logic [BANK_BITW:0]    out_fill;

    line_buffer_ctrl #(.WIDTH_MAX(WIDTH_MAX), .LINES(LINES), .PIXEL_BITW(PIXEL_BITW)) dut (
        .clock(clock), .reset(reset), .in_frame_start(in_frame_start), .in_width(in_width),
        .in_valid(in_valid), .in_pixel(in_pixel), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .out_valid(out_valid),
        .out_pixel(out_pixel), .out_col(out_col), .out_last_col(out_last_col),
        .out_oldest_bank(out_oldest_bank), .out_fill(out_fill)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int unsigned           due;
        logic [LINES-1:0]      en;
        logic [ADDR_BITW-1:0]  col;
        logic [PIXEL_BITW-1:0] pix;
        logic                  valid;
        logic                  last;
        logic [BANK_BITW-1:0]  oldest;
        logic [BANK_BITW:0]    fill;
    } exp_t;

    exp_t ram_q[$];
    exp_t exp_q[$];
    int   n_pix;
    int   w_cur;
    int   cyc;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
            e = ram_q.pop_front();
            chk("ram_wr_en", 32'(ram_wr_en), 32'(e.en));
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e.col));
            chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e.col));
            chk("ram_wr_data", 32'(ram_wr_data), 32'(e.pix));
        end else begin
            chk("ram_wr_en_idle", 32'(ram_wr_en), 32'd0);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.valid));
            chk("out_pixel", 32'(out_pixel), 32'(e.pix));
            chk("out_col", 32'(out_col), 32'(e.col));
            chk("out_last_col", 32'(out_last_col), 32'(e.last));
            chk("out_oldest_bank", 32'(out_oldest_bank), 32'(e.oldest));
            chk("out_fill", 32'(out_fill), 32'(e.fill));
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
        end
    endtask

    // One clock: apply inputs, predict from the pixel index, check after the edge
    task automatic drive(input logic fs, input logic v, input logic [PIXEL_BITW-1:0] pix, input int w);
        exp_t e;
        int   line;
        int   c;
        in_frame_start = fs;
        in_valid       = v;
        in_pixel       = pix;
        in_width       = (ADDR_BITW+1)'(w);
        if (fs) begin
            n_pix = 0;
            w_cur = (w == 0) ? WIDTH_MAX : w;
        end
        if (v) begin
            line     = n_pix / w_cur;
            c        = n_pix % w_cur;
            e.due    = cyc + 1;
            e.en     = LINES'(1 << (line % LINES));
            e.col    = ADDR_BITW'(c);
            e.pix    = pix;
            e.last   = (c == w_cur - 1);
            e.oldest = BANK_BITW'((line + 1) % LINES);
            e.fill   = (BANK_BITW+1)'((line < LINES - 1) ? line : LINES - 1);
`ifdef LINE_BUFFER_CTRL_EARLY_OUT_EN
            e.valid  = 1'b1;
`else
            e.valid  = (line >= LINES - 1);
`endif
            ram_q.push_back(e);
            e.due = cyc + 2;
            exp_q.push_back(e);
            n_pix++;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check_cycle();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, '0, 0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        in_frame_start = 1'b0;
        in_valid       = 1'b0;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        ram_q.delete();
        exp_q.delete();
        n_pix = 0;
        w_cur = WIDTH_MAX;
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(ram_wr_data), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        chk("rst_out_last", 32'(out_last_col), 32'd0);
        chk("rst_out_oldest", 32'(out_oldest_bank), 32'd0);
        chk("rst_out_fill", 32'(out_fill), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        in_frame_start = 1'b0;
        in_width       = '0;
        in_valid       = 1'b0;
        in_pixel       = '0;
        n_pix = 0; w_cur = WIDTH_MAX; cyc = 0; tests = 0; fails = 0;
        do_reset();
        do_reset();

        // Width 4, 16 back-to-back pixels: banks 0,1,2 then wrap to 0
        drive(1'b1, 1'b0, '0, 4);
        for (int p = 0; p < 16; p++) drive(1'b0, 1'b1, PIXEL_BITW'(p), 4);
        idle(3);

        // Gapped input, one pixel every third cycle
        drive(1'b1, 1'b0, '0, 4);
        for (int p = 0; p < 16; p++) begin
            drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 4);
            idle(2);
        end

        // Frame start with a pixel, mid-line after fill reached full
        for (int p = 0; p < 6; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 4);
        drive(1'b1, 1'b1, 8'hA5, 4);
        for (int p = 0; p < 9; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 4);
        idle(2);

        // Width 0 means WIDTH_MAX
        drive(1'b1, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 0);
        for (int p = 0; p < 40; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 0);
        idle(2);

        // Width 1: every pixel ends a line
        drive(1'b1, 1'b0, '0, 1);
        for (int p = 0; p < 8; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 1);

        // Reset mid-line, then a new frame restarts at bank 0 column 0
        drive(1'b1, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 5);
        for (int p = 0; p < 7; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 5);
        do_reset();
        drive(1'b1, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 3);
        for (int p = 0; p < 10; p++) drive(1'b0, 1'b1, PIXEL_BITW'($urandom_range(0, 255)), 3);

        // Random traffic with occasional frame starts and random widths
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  PIXEL_BITW'($urandom_range(0, 255)), $urandom_range(0, WIDTH_MAX));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for a bank of `LINES` single-word-per-pixel line RAMs (`ram_dc` instances, both ports on one clock) in the image processor's vertical-window path. It receives a raster pixel stream and rotates writes across the banks line by line. It drives a shared column read address so that all older lines can be read in parallel. It emits a valid strobe, aligned to the RAMs' 1-cycle read latency, once a full `LINES`-tall column window is available.

## Interface
- `WIDTH_MAX`, default 2048: maximum pixels per line; RAM depth. `ADDR_BITW = $clog2(WIDTH_MAX)`.
- `LINES`, default 3: number of line RAM banks, which is also the window height. Must be ≥ 2. `BANK_BITW = $clog2(LINES)`.
- `PIXEL_BITW`, default 8: pixel width.

Ports:
- `clock`, in, 1: single clock for the block and all banks. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `in_frame_start`, in, 1: one-cycle pulse. Clears counters and latches `in_width`.
- `in_width`, in, ADDR_BITW+1: active line width, 1..WIDTH_MAX. A value of 0 is treated as WIDTH_MAX.
- `in_valid`, in, 1: `in_pixel` is accepted this cycle. There is no backpressure.
- `in_pixel`, in, PIXEL_BITW: incoming pixel.
- `ram_wr_en`, out, LINES: one-hot bank write enable.
- `ram_wr_addr`, out, ADDR_BITW: write column, common to all banks.
- `ram_wr_data`, out, PIXEL_BITW: write data, common to all banks.
- `ram_rd_addr`, out, ADDR_BITW: read column, common to all banks.
- `out_valid`, out, 1: window column is valid on the bank `rd_data` outputs this cycle.
- `out_pixel`, out, PIXEL_BITW: current-line pixel, aligned with `out_valid`.
- `out_col`, out, ADDR_BITW: column of the window.
- `out_last_col`, out, 1: `out_col == width-1`.
- `out_oldest_bank`, out, BANK_BITW: bank holding the oldest line. Bank order is `oldest`, `oldest+1` … modulo LINES, excluding the bank currently being written.
- `out_fill`, out, BANK_BITW+1: number of completed previous lines available, saturating at LINES-1.

## Operation
- State:
  - `col` (0..width-1)
  - `wr_bank` (0..LINES-1)
  - `fill` (0..LINES-1)
  - `width_r`
- On `in_frame_start`:
  - `col` ← 0, `wr_bank` ← 0, `fill` ← 0, `width_r` ← `in_width` (0 maps to WIDTH_MAX).
  - If `in_valid` is asserted in the same cycle, that pixel is column 0 of the new frame and the counters advance from that cleared state.
- On accepted pixel (`in_valid`):
  - Registered outputs: `ram_wr_en` ← one-hot(`wr_bank`), `ram_wr_addr` ← `col`, `ram_rd_addr` ← `col`, `ram_wr_data` ← `in_pixel`.
  - `col` increments.
  - If `col == width_r-1`, then:
    - `col` ← 0;
    - `wr_bank` ← `wr_bank+1`, wrapping LINES-1 → 0;
    - `fill` ← min(`fill+1`, LINES-1).
- On cycles without `in_valid`: `ram_wr_en` ← 0 and the counters hold. The address registers hold their values.
- A read of the bank being written returns stale data. The datapath ignores that bank.
- `out_oldest_bank` = (`wr_bank`+1) mod LINES, sampled at the accept cycle and delayed to align with `out_valid`.
- Window qualification: `out_valid` is asserted only for pixels accepted while `fill == LINES-1`.

## Timing
- Reset values:
  - all outputs 0;
  - `col`, `wr_bank`, `fill` = 0;
  - `width_r` = WIDTH_MAX.
- Reset mid-line discards the partial line and all fill.
- A pixel accepted at cycle t produces:
  - `ram_wr_*` and `ram_rd_addr` at t+1;
  - RAM `rd_data` at t+2;
  - `out_valid`, `out_pixel`, `out_col`, `out_last_col`, `out_oldest_bank`, `out_fill` at t+2. Fixed latency 2.
- Back-to-back `in_valid` sustains 1 pixel per clock.
- Write and read hit the same column only in different banks; there is no intra-bank conflict.
- A width of 1 means every pixel ends a line, so the bank advances each accept.
- `in_frame_start` arriving mid-line takes precedence: the partial line is discarded. Outputs already in the 2-stage pipeline still complete.

## Configuration
- `LINE_BUFFER_CTRL_EARLY_OUT_EN`:
  - When defined, `out_valid` is asserted for every accepted pixel from row 0 of the frame. The datapath uses `out_fill` to replicate or zero the missing top rows.
  - When undefined, `out_valid` is asserted only when `fill == LINES-1`.
  - `out_fill` is present in both builds.

## Test plan
All scenarios use LINES=3 and WIDTH_MAX=16 unless stated otherwise.
- Reset, then `in_frame_start` with width 4, then 12 consecutive pixels 0..11:
  - `ram_wr_en` sequence is 001 ×4, 010 ×4, 100 ×4;
  - `out_valid` is first asserted 2 cycles after pixel 8 is accepted, with `out_col=0`, `out_oldest_bank=0` and `out_fill=2`.
- Continue with 4 more pixels:
  - `ram_wr_en`=001, because the bank wraps;
  - `out_oldest_bank`=1;
  - `out_last_col` is asserted on the 4th pixel's output.
- Gapped `in_valid` (1 of every 3 cycles) at width 4: identical counter results; every output arrives exactly 2 cycles after its accept.
- `in_frame_start` with `in_valid` in the same cycle, mid-line:
  - the pixel writes to bank 0 at column 0;
  - `out_fill` returns to 0;
  - `out_valid` stays low for the next 8 pixels (non-EN build).
- Width 0: line wraps after 16 pixels. Width 1: bank advances every accept.
- With `LINE_BUFFER_CTRL_EARLY_OUT_EN` defined: `out_valid` follows each of the first pixels at +2 cycles, with `out_fill` = 0, 0, 0, 0, 1, …
- Reset asserted mid-line:
  - the next cycle shows all outputs 0;
  - a subsequent frame starts at bank 0, column 0.
